multi_timer: RTL and testbench

Parametrised multi-channel countdown timer for the traffic-light and game controllers. It contains one free-running prescaler that produces 1 Hz and 2 Hz enable strobes. It also contains NUM_CH independent channels; each one loads a second-count, decrements once per 1 Hz strobe, and signals expiry. Pause, cancel and an optional auto-reload mode are added over the single-channel timer it replaces.

---
 rtl/timer_pkg.sv | 7 +
 rtl/timer_channel.sv | 88 ++++++++
 rtl/multi_timer.sv | 68 ++++++
 tb/tb_multi_timer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared channel state enum and prescaler width helper for multi_timer
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} ch_state_t;
  function automatic int presc_w(input int clk_hz);
    return (clk_hz / 2 > 1) ? $clog2(clk_hz / 2) : 1;
  endfunction
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one countdown channel (IDLE/RUN/PAUSED/EXPIRED) decremented by a 1 Hz tick
//   i_tick one-cycle 1 Hz strobe; i_start load-and-run; i_pause freeze level; i_cancel back to IDLE
//   i_reload auto-reload request sampled with i_start (only with TIMER_AUTORELOAD_EN)
//   o_count remaining seconds; o_expired level in EXPIRED; o_expire_pulse one cycle per expiry
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic             i_start,
  input  logic             i_pause,
  input  logic             i_cancel,
`ifdef TIMER_AUTORELOAD_EN
  input  logic             i_reload,
`endif
  input  logic [CNT_W-1:0] i_value,
  output logic [CNT_W-1:0] o_count,
  output logic             o_expired,
  output logic             o_expire_pulse
);
  ch_state_t        r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_expired;
  logic             r_pulse;
  logic             w_zero;
  logic             w_mode;
  logic [CNT_W-1:0] w_reload_val;
  assign w_zero = (i_value == '0);
`ifdef TIMER_AUTORELOAD_EN
  logic             r_mode;
  logic [CNT_W-1:0] r_reload_val;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_mode       <= 1'b0;
      r_reload_val <= '0;
    end else if (i_start) begin
      r_mode       <= i_reload;
      r_reload_val <= i_value;
    end
  assign w_mode       = r_mode;
  assign w_reload_val = r_reload_val;
`else
  assign w_mode       = 1'b0;
  assign w_reload_val = '0;
`endif
  // start beats cancel, cancel beats pause/tick; pause in RUN swallows a same-cycle tick
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_expired <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (i_start) begin
        r_state   <= w_zero ? EXPIRED : RUN;
        r_count   <= i_value;
        r_expired <= w_zero;
        r_pulse   <= w_zero;
      end else if (i_cancel) begin
        r_state   <= IDLE;
        r_count   <= '0;
        r_expired <= 1'b0;
      end else begin
        case (r_state)
          RUN:
            if (i_pause) r_state <= PAUSED;
            else if (i_tick) begin
              if (r_count > CNT_W'(1)) r_count <= r_count - CNT_W'(1);
              else begin
                r_pulse   <= 1'b1;
                r_count   <= w_mode ? w_reload_val : '0;
                r_state   <= w_mode ? RUN : EXPIRED;
                r_expired <= !w_mode;
              end
            end
          PAUSED:  if (!i_pause) r_state <= RUN;
          default: ;
        endcase
      end
    end
  assign o_count        = r_count;
  assign o_expired      = r_expired;
  assign o_expire_pulse = r_pulse;
endmodule

// File: rtl/multi_timer.sv
// multi_timer: free-running 1 Hz / 2 Hz prescaler plus NUM_CH independent countdown channels
//   i_value per-channel load values (channel i at [i*CNT_W +: CNT_W]); i_start/i_pause/i_cancel per channel
//   i_reload per-channel auto-reload request, present only when TIMER_AUTORELOAD_EN is defined
//   o_count per-channel remaining seconds; o_expired / o_expire_pulse per channel
//   o_one_hz_enable strobe every CLK_HZ cycles; o_two_hz_enable strobe every CLK_HZ/2 cycles
module multi_timer
  import timer_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W  = 5,
  parameter int NUM_CH = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_CH*CNT_W-1:0] i_value,
  input  logic [NUM_CH-1:0]       i_start,
  input  logic [NUM_CH-1:0]       i_pause,
  input  logic [NUM_CH-1:0]       i_cancel,
`ifdef TIMER_AUTORELOAD_EN
  input  logic [NUM_CH-1:0]       i_reload,
`endif
  output logic [NUM_CH*CNT_W-1:0] o_count,
  output logic [NUM_CH-1:0]       o_expired,
  output logic [NUM_CH-1:0]       o_expire_pulse,
  output logic                    o_one_hz_enable,
  output logic                    o_two_hz_enable
);
  localparam int HALF = CLK_HZ / 2;
  localparam int PW   = presc_w(CLK_HZ);
  logic [PW-1:0] r_presc;
  logic          r_phase;
  logic          r_one_hz;
  logic          r_two_hz;
  logic          w_wrap;
  assign w_wrap = (r_presc == PW'(HALF - 1));
  // phase starts at 0, so 1 Hz joins the second 2 Hz strobe and every other one after
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_presc  <= '0;
      r_phase  <= 1'b0;
      r_one_hz <= 1'b0;
      r_two_hz <= 1'b0;
    end else begin
      r_presc  <= w_wrap ? '0 : r_presc + PW'(1);
      r_phase  <= r_phase ^ w_wrap;
      r_two_hz <= w_wrap;
      r_one_hz <= w_wrap & r_phase;
    end
  assign o_one_hz_enable = r_one_hz;
  assign o_two_hz_enable = r_two_hz;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_tick         (r_one_hz),
      .i_start        (i_start[i]),
      .i_pause        (i_pause[i]),
      .i_cancel       (i_cancel[i]),
`ifdef TIMER_AUTORELOAD_EN
      .i_reload       (i_reload[i]),
`endif
      .i_value        (i_value[i*CNT_W +: CNT_W]),
      .o_count        (o_count[i*CNT_W +: CNT_W]),
      .o_expired      (o_expired[i]),
      .o_expire_pulse (o_expire_pulse[i])
    );
  end
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed table-driven bench for multi_timer with CLK_HZ=8, CNT_W=5, NUM_CH=2
module tb_multi_timer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] value = '0;
  logic [1:0] start = '0, pause = '0, cancel = '0;
`ifdef TIMER_AUTORELOAD_EN
  logic [1:0] reload = '0;
`endif
  logic [9:0] count;
  logic [1:0] expired, expire_pulse;
  logic       one_hz, two_hz;
  int         tests = 0, fails = 0;

  typedef struct {
    int         n;
    logic [1:0] st, cn, ps, rl;
    logic [9:0] val;
    logic [4:0] c0, c1;
    logic [1:0] ex, pl;
  } vec_t;
  vec_t q[$];

  multi_timer #(.CLK_HZ(8), .CNT_W(5), .NUM_CH(2)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_value         (value),
    .i_start         (start),
    .i_pause         (pause),
    .i_cancel        (cancel),
`ifdef TIMER_AUTORELOAD_EN
    .i_reload        (reload),
`endif
    .o_count         (count),
    .o_expired       (expired),
    .o_expire_pulse  (expire_pulse),
    .o_one_hz_enable (one_hz),
    .o_two_hz_enable (two_hz)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_count"}, 32'(count), 0);
    chk({nm, "_exp"}, 32'(expired), 0);
    chk({nm, "_pulse"}, 32'(expire_pulse), 0);
    chk({nm, "_1hz"}, 32'(one_hz), 0);
    chk({nm, "_2hz"}, 32'(two_hz), 0);
  endtask

  // each entry: drive for one edge (start/cancel then drop), hold pause for n edges, then compare
  task automatic run_table(input string tag);
    for (int i = 0; i < q.size(); i++) begin
      start  = q[i].st;
      cancel = q[i].cn;
      pause  = q[i].ps;
      value  = q[i].val;
`ifdef TIMER_AUTORELOAD_EN
      reload = q[i].rl;
`endif
      step(1);
      start  = '0;
      cancel = '0;
      if (q[i].n > 1) step(q[i].n - 1);
      chk($sformatf("%s%0d_c0", tag, i), 32'(count[4:0]), 32'(q[i].c0));
      chk($sformatf("%s%0d_c1", tag, i), 32'(count[9:5]), 32'(q[i].c1));
      chk($sformatf("%s%0d_exp", tag, i), 32'(expired), 32'(q[i].ex));
      chk($sformatf("%s%0d_pulse", tag, i), 32'(expire_pulse), 32'(q[i].pl));
    end
    q.delete();
  endtask

  initial begin
    #12;
    chk_zero("rst_hold");
    rst = 1'b0;
    #1;
    chk_zero("rst_rel");
    // prescaler: 2 Hz after edges 4,8,12,16; 1 Hz after 8,16; ticks consumed at edges 9,17,25,...
    for (int k = 1; k <= 17; k++) begin
      step(1);
      chk($sformatf("pre%0d_2hz", k), 32'(two_hz), 32'(k % 4 == 0));
      chk($sformatf("pre%0d_1hz", k), 32'(one_hz), 32'(k % 8 == 0));
    end
    chk("pre_counts", 32'(count), 0);
    // k=17 here
    q.push_back('{1,  2'b11, 2'b00, 2'b00, 2'b00, {5'd0, 5'd3}, 5'd3, 5'd0, 2'b10, 2'b10});
    q.push_back('{1,  2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd3, 5'd0, 2'b10, 2'b00});
    q.push_back('{5,  2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd3, 5'd0, 2'b10, 2'b00});
    q.push_back('{1,  2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd2, 5'd0, 2'b10, 2'b00});
    q.push_back('{8,  2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd1, 5'd0, 2'b10, 2'b00});
    q.push_back('{7,  2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd1, 5'd0, 2'b10, 2'b00});
    q.push_back('{1,  2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd0, 5'd0, 2'b11, 2'b01});
    q.push_back('{1,  2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd0, 5'd0, 2'b11, 2'b00});
    q.push_back('{1,  2'b00, 2'b11, 2'b00, 2'b00, 10'd0,        5'd0, 5'd0, 2'b00, 2'b00});
    // pause across ticks 49 and 57, release at 62, expire on the 4th later tick (89)
    q.push_back('{1,  2'b01, 2'b00, 2'b00, 2'b00, {5'd0, 5'd4}, 5'd4, 5'd0, 2'b00, 2'b00});
    q.push_back('{1,  2'b00, 2'b00, 2'b01, 2'b00, 10'd0,        5'd4, 5'd0, 2'b00, 2'b00});
    q.push_back('{16, 2'b00, 2'b00, 2'b01, 2'b00, 10'd0,        5'd4, 5'd0, 2'b00, 2'b00});
    q.push_back('{1,  2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd4, 5'd0, 2'b00, 2'b00});
    q.push_back('{3,  2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd3, 5'd0, 2'b00, 2'b00});
    q.push_back('{16, 2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd1, 5'd0, 2'b00, 2'b00});
    q.push_back('{7,  2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd1, 5'd0, 2'b00, 2'b00});
    q.push_back('{1,  2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd0, 5'd0, 2'b01, 2'b01});
    // restart from EXPIRED, then pause lands exactly on tick edge 97 and swallows it
    q.push_back('{1,  2'b01, 2'b00, 2'b00, 2'b00, {5'd0, 5'd5}, 5'd5, 5'd0, 2'b00, 2'b00});
    q.push_back('{6,  2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd5, 5'd0, 2'b00, 2'b00});
    q.push_back('{1,  2'b00, 2'b00, 2'b01, 2'b00, 10'd0,        5'd5, 5'd0, 2'b00, 2'b00});
    q.push_back('{1,  2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd5, 5'd0, 2'b00, 2'b00});
    q.push_back('{7,  2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd4, 5'd0, 2'b00, 2'b00});
    // start+cancel on ch1 -> start wins; cancel ch0 leaves ch1 running
    q.push_back('{1,  2'b10, 2'b10, 2'b00, 2'b00, {5'd7, 5'd0}, 5'd4, 5'd7, 2'b00, 2'b00});
    q.push_back('{1,  2'b00, 2'b01, 2'b00, 2'b00, 10'd0,        5'd0, 5'd7, 2'b00, 2'b00});
    q.push_back('{6,  2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd0, 5'd6, 2'b00, 2'b00});
    run_table("t");
    // asynchronous reset mid-count with ch0 at 2
    value = {5'd0, 5'd2};
    start = 2'b01;
    step(1);
    start = '0;
    chk("mid_c0", 32'(count[4:0]), 2);
    #3 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(posedge clk);
    #1 chk_zero("rst_edge");
    #2 rst = 1'b0;
    step(3);
    chk("rst2_2hz_k3", 32'(two_hz), 0);
    step(1);
    chk("rst2_2hz_k4", 32'(two_hz), 1);
    chk("rst2_1hz_k4", 32'(one_hz), 0);
    chk("rst2_counts", 32'(count), 0);
    chk("rst2_pulse", 32'(expire_pulse), 0);
`ifdef TIMER_AUTORELOAD_EN
    // k=4: ticks at 9,17,25,33; reload every second tick, expired never set
    q.push_back('{1, 2'b01, 2'b00, 2'b00, 2'b01, {5'd0, 5'd2}, 5'd2, 5'd0, 2'b00, 2'b00});
    q.push_back('{4, 2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd1, 5'd0, 2'b00, 2'b00});
    q.push_back('{8, 2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd2, 5'd0, 2'b00, 2'b01});
    q.push_back('{1, 2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd2, 5'd0, 2'b00, 2'b00});
    q.push_back('{7, 2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd1, 5'd0, 2'b00, 2'b00});
    q.push_back('{8, 2'b00, 2'b00, 2'b00, 2'b00, 10'd0,        5'd2, 5'd0, 2'b00, 2'b01});
    q.push_back('{1, 2'b00, 2'b01, 2'b00, 2'b00, 10'd0,        5'd0, 5'd0, 2'b00, 2'b00});
    run_table("ar");
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
